// File: rtl/clkgate_ctrl.sv
// Idle-driven clock-gate controller: stops the gated clock after IDLE_CYCLES quiet cycles
// and restarts it on busy/wake_req. Optional force_on input when CLKGATE_CTRL_FORCE_ON_EN is defined.
module clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic wake_req,
`ifdef CLKGATE_CTRL_FORCE_ON_EN
  input  logic force_on,
`endif
  output logic clk_en,
  output logic wake_ack,
  output logic gated
);

  localparam int CW_I = $clog2(IDLE_CYCLES);
  localparam int CW_W = $clog2(WAKE_CYCLES);
  localparam int CW_M = (CW_I > CW_W) ? CW_I : CW_W;
  // A one-cycle configuration would give a zero-width counter; keep at least one bit.
  localparam int CW   = (CW_M > 0) ? CW_M : 1;

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    IDLE = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          force_act;
  logic          act;
  logic          ack_nxt;

`ifdef CLKGATE_CTRL_FORCE_ON_EN
  assign force_act = force_on;
`else
  assign force_act = 1'b0;
`endif

  assign act = busy | wake_req | force_act;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        // An open handshake (request or acknowledge still high) pins the clock on.
        if (!act && !wake_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: begin
        if (act) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = OFF;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      OFF: begin
        if (act) begin
          state_nxt = WAKE;
          cnt_nxt   = '0;
        end
      end
      WAKE: begin
        if (cnt == WAKE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Acknowledge only once the clock has been running for a full cycle in RUN.
  assign ack_nxt = (state == RUN) && (state_nxt == RUN) && wake_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= '0;
      clk_en   <= 1'b1;
      wake_ack <= 1'b0;
      gated    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clk_en   <= (state_nxt != OFF);
      gated    <= (state_nxt == OFF);
      wake_ack <= ack_nxt;
    end
  end

endmodule
